// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN operand stack: default sizes, ALU op codes
// and the execute sequencer state encoding.
package rpn_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10
    } state_t;

endpackage

// File: rtl/rpn_stack_regfile.sv
// DEPTH x WIDTH stack storage: one write port, reads of the top and
// second-from-top entries indexed by the live entry count, and clear-all.
module rpn_stack_regfile
    import rpn_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] rd_top,
    output logic [WIDTH-1:0] rd_next
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    idx_top_s;
    logic [AW-1:0]    idx_next_s;

    assign idx_top_s  = AW'(count - CW'(1));
    assign idx_next_s = AW'(count - CW'(2));

    // Storage update: reset and clear wipe every entry, otherwise one write.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read ports return zero for positions below the bottom of the stack.
    always_comb begin
        rd_top  = '0;
        rd_next = '0;
        if (count > CW'(0)) begin
            rd_top = mem_r[idx_top_s];
        end else begin
            rd_top = '0;
        end
        if (count > CW'(1)) begin
            rd_next = mem_r[idx_next_s];
        end else begin
            rd_next = '0;
        end
    end

endmodule

// File: rtl/rpn_operand_stack.sv
// RPN operand stack with a three-state execute sequencer feeding an external
// combinational ALU and capturing its result and carry/borrow flag.
module rpn_operand_stack
    import rpn_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [WIDTH-1:0]           Data_in,
    input  logic                       Push,
    input  logic                       Exec,
    input  logic                       Clear,
    input  logic [2:0]                 Op_in,
    input  logic [WIDTH-1:0]           Alu_res,
    input  logic                       Flag_c,
    output logic [WIDTH-1:0]           Alu_a,
    output logic [WIDTH-1:0]           Alu_b,
    output logic [2:0]                 Sel,
    output logic [WIDTH-1:0]           Top,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Busy,
    output logic                       Carry_flag,
    output logic                       Err_over,
    output logic                       Err_under
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t           state_r, state_nxt;
    logic [CW-1:0]    count_r, count_nxt;
    logic [WIDTH-1:0] alu_a_r, alu_a_nxt;
    logic [WIDTH-1:0] alu_b_r, alu_b_nxt;
    logic [2:0]       sel_r, sel_nxt;
    logic             carry_r, carry_nxt;
    logic             err_over_r, err_over_nxt;
    logic             err_under_r, err_under_nxt;

    logic             we_s;
    logic             clr_s;
    logic [AW-1:0]    waddr_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] rd_top_s;
    logic [WIDTH-1:0] rd_next_s;

    rpn_stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) u_regfile (
        .clk     (Clk),
        .reset_n (Reset_n),
        .clear   (clr_s),
        .we      (we_s),
        .waddr   (waddr_s),
        .wdata   (wdata_s),
        .count   (count_r),
        .rd_top  (rd_top_s),
        .rd_next (rd_next_s)
    );

    // Sequencer next-state, stack write control and status updates.
    always_comb begin
        state_nxt     = state_r;
        count_nxt     = count_r;
        alu_a_nxt     = alu_a_r;
        alu_b_nxt     = alu_b_r;
        sel_nxt       = sel_r;
        carry_nxt     = carry_r;
        err_over_nxt  = err_over_r;
        err_under_nxt = err_under_r;
        we_s          = 1'b0;
        clr_s         = 1'b0;
        waddr_s       = '0;
        wdata_s       = '0;

        case (state_r)
            ST_IDLE: begin
                if (Clear) begin
                    clr_s         = 1'b1;
                    count_nxt     = '0;
                    err_over_nxt  = 1'b0;
                    err_under_nxt = 1'b0;
                end else if (Push) begin
                    if (count_r < CW'(DEPTH)) begin
                        we_s          = 1'b1;
                        waddr_s       = AW'(count_r);
                        wdata_s       = Data_in;
                        count_nxt     = count_r + CW'(1);
                        err_over_nxt  = 1'b0;
                        err_under_nxt = 1'b0;
                    end else begin
                        err_over_nxt = 1'b1;
                    end
                end else if (Exec) begin
                    if (count_r < CW'(2)) begin
                        err_under_nxt = 1'b1;
                    end else begin
                        alu_a_nxt = rd_next_s;
                        alu_b_nxt = rd_top_s;
                        sel_nxt   = Op_in;
                        state_nxt = ST_ISSUE;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Alu_a/Alu_b/Sel settle through the ALU during this cycle.
                if (Clear) begin
                    clr_s         = 1'b1;
                    count_nxt     = '0;
                    err_over_nxt  = 1'b0;
                    err_under_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end else begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (Clear) begin
                    clr_s         = 1'b1;
                    count_nxt     = '0;
                    err_over_nxt  = 1'b0;
                    err_under_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end else begin
                    // Result replaces the lower operand; the top slot is popped.
                    we_s          = 1'b1;
                    waddr_s       = AW'(count_r - CW'(2));
                    wdata_s       = Alu_res;
                    count_nxt     = count_r - CW'(1);
                    carry_nxt     = Flag_c;
                    err_over_nxt  = 1'b0;
                    err_under_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r     <= ST_IDLE;
            count_r     <= '0;
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            sel_r       <= 3'b000;
            carry_r     <= 1'b0;
            err_over_r  <= 1'b0;
            err_under_r <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            count_r     <= count_nxt;
            alu_a_r     <= alu_a_nxt;
            alu_b_r     <= alu_b_nxt;
            sel_r       <= sel_nxt;
            carry_r     <= carry_nxt;
            err_over_r  <= err_over_nxt;
            err_under_r <= err_under_nxt;
        end
    end

    assign Alu_a      = alu_a_r;
    assign Alu_b      = alu_b_r;
    assign Sel        = sel_r;
    assign Top        = rd_top_s;
    assign Count      = count_r;
    assign Busy       = (state_r != ST_IDLE);
    assign Carry_flag = carry_r;
    assign Err_over   = err_over_r;
    assign Err_under  = err_under_r;

endmodule
